// File: rtl/trace_event_counter_bank_if.sv
// Control, read/write window and status bundle for trace_event_counter_bank.
// The master side drives the controls, and the counter bank is the slave.
interface trace_event_counter_bank_if #(
  parameter int NUM_EVENTS = 34
);
  localparam int SEL_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

  logic [NUM_EVENTS-1:0] events_in;
  logic                  enable;
  logic                  unfreeze;
  logic                  snapshot;
  logic                  clear_all;
  logic [SEL_W-1:0]      sel;
  logic                  hi_sel;
  logic                  rd_shadow;
  logic                  rd_req;
  logic                  rd_valid;
  logic [31:0]           rd_data;
  logic                  wr_en;
  logic [31:0]           wr_data;
  logic [NUM_EVENTS-1:0] ovf_flags;
  logic                  frozen;

  modport master (
    output events_in, enable, unfreeze, snapshot, clear_all, sel, hi_sel,
           rd_shadow, rd_req, wr_en, wr_data,
    input  rd_valid, rd_data, ovf_flags, frozen
  );

  modport slave (
    input  events_in, enable, unfreeze, snapshot, clear_all, sel, hi_sel,
           rd_shadow, rd_req, wr_en, wr_data,
    output rd_valid, rd_data, ovf_flags, frozen
  );
endinterface

// File: rtl/trace_event_counter_bank.sv
// Bank of per-event counters with a run/freeze FSM, wrap or saturate overflow,
// sticky overflow flags, snapshot shadows and a 32-bit read/write window.
module trace_event_counter_bank #(
  parameter int NUM_EVENTS    = 34,
  parameter int COUNTER_W     = 32,
  parameter bit SATURATE      = 1'b0,
  parameter bit FREEZE_ON_OVF = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  trace_event_counter_bank_if.slave bus
);
  localparam int SEL_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
  localparam logic [COUNTER_W-1:0] CNT_MAX  = {COUNTER_W{1'b1}};
  localparam logic [COUNTER_W-1:0] CNT_ZERO = {COUNTER_W{1'b0}};
  localparam logic [COUNTER_W-1:0] CNT_ONE  = COUNTER_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  // Replace one 32-bit half of a counter value, and leave the other half unchanged.
  function automatic logic [63:0] wr_merge(input logic [COUNTER_W-1:0] old_val,
                                           input logic hi, input logic [31:0] data);
    logic [63:0] tmp;
    tmp = 64'(old_val);
    if (hi) begin
      tmp[63:32] = data;
    end else begin
      tmp[31:0] = data;
    end
    return tmp;
  endfunction

  state_t                state_r, state_next_s;
  logic                  run_s, frozen_s, hi_eff_s;
  logic [NUM_EVENTS-1:0] events_r, ovf_r, wr_hit_s, ovf_evt_s;
  logic [COUNTER_W-1:0]  cnt_r    [NUM_EVENTS];
  logic [COUNTER_W-1:0]  shadow_r [NUM_EVENTS];
  logic [63:0]           rd_val_s;
  logic                  rd_valid_r;
  logic [31:0]           rd_data_r;

  assign hi_eff_s = bus.hi_sel & (COUNTER_W > 32);

  // Decode the selected counter and find increments that overflow. A clear or a write discards the increment.
  always_comb begin
    wr_hit_s  = '0;
    ovf_evt_s = '0;
    rd_val_s  = 64'd0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        wr_hit_s[i] = bus.wr_en;
        rd_val_s    = bus.rd_shadow ? 64'(shadow_r[i]) : 64'(cnt_r[i]);
      end else begin
        wr_hit_s[i] = 1'b0;
      end
      ovf_evt_s[i] = run_s & events_r[i] & (cnt_r[i] == CNT_MAX) & ~bus.clear_all & ~wr_hit_s[i];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.enable) state_next_s = ST_RUN;
        else            state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!bus.enable)                        state_next_s = ST_IDLE;
        else if (FREEZE_ON_OVF && |ovf_evt_s)   state_next_s = ST_FROZEN;
        else                                    state_next_s = ST_RUN;
      end
      ST_FROZEN: begin
        if (bus.unfreeze || bus.clear_all) state_next_s = bus.enable ? ST_RUN : ST_IDLE;
        else                               state_next_s = ST_FROZEN;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs are decoded only from the state register.
  always_comb begin
    run_s    = 1'b0;
    frozen_s = 1'b0;
    case (state_r)
      ST_RUN:    run_s    = 1'b1;
      ST_FROZEN: frozen_s = 1'b1;
      default: begin
        run_s    = 1'b0;
        frozen_s = 1'b0;
      end
    endcase
  end

  // Event input stage, counters, shadows and sticky flags. Priority is clear, then write, then increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      events_r <= '0;
      ovf_r    <= '0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt_r[i]    <= CNT_ZERO;
        shadow_r[i] <= CNT_ZERO;
      end
    end else begin
      events_r <= bus.events_in;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (bus.clear_all) begin
          cnt_r[i]    <= CNT_ZERO;
          shadow_r[i] <= CNT_ZERO;
          ovf_r[i]    <= 1'b0;
        end else begin
          if (bus.snapshot) shadow_r[i] <= cnt_r[i];
          if (wr_hit_s[i]) begin
            cnt_r[i] <= COUNTER_W'(wr_merge(cnt_r[i], hi_eff_s, bus.wr_data));
          end else if (run_s && events_r[i]) begin
            cnt_r[i] <= (cnt_r[i] == CNT_MAX) ? (SATURATE ? CNT_MAX : CNT_ZERO)
                                              : cnt_r[i] + CNT_ONE;
          end
          if (ovf_evt_s[i]) ovf_r[i] <= 1'b1;
        end
      end
    end
  end

  // Read response is registered one cycle after the request and held until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= 32'd0;
    end else begin
      rd_valid_r <= bus.rd_req;
      if (bus.rd_req) rd_data_r <= hi_eff_s ? rd_val_s[63:32] : rd_val_s[31:0];
    end
  end

  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.ovf_flags = ovf_r;
  assign bus.frozen    = frozen_s;
endmodule

// File: tb/tb_trace_event_counter_bank.sv
// Self-checking bench that drives three configurations (40-bit wrap/freeze, 8-bit wrap/freeze, 8-bit saturate)
// from one stimulus stream and compares them with an arithmetic reference model.
module tb_trace_event_counter_bank;
  localparam int NE = 34;
  localparam int NC = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_FROZEN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NE-1:0] ev;
  logic          en, unf, snap, clr, hi, rsh, rreq, wen;
  logic [5:0]    sel;
  logic [31:0]   wd;

  logic          rdv_o [NC];
  logic [31:0]   rdd_o [NC];
  logic [NE-1:0] ovf_o [NC];
  logic          frz_o [NC];

  for (genvar g = 0; g < NC; g++) begin : g_dut
    trace_event_counter_bank_if #(.NUM_EVENTS(NE)) bus ();
    assign bus.events_in = ev;
    assign bus.enable    = en;
    assign bus.unfreeze  = unf;
    assign bus.snapshot  = snap;
    assign bus.clear_all = clr;
    assign bus.sel       = sel;
    assign bus.hi_sel    = hi;
    assign bus.rd_shadow = rsh;
    assign bus.rd_req    = rreq;
    assign bus.wr_en     = wen;
    assign bus.wr_data   = wd;
    assign rdv_o[g] = bus.rd_valid;
    assign rdd_o[g] = bus.rd_data;
    assign ovf_o[g] = bus.ovf_flags;
    assign frz_o[g] = bus.frozen;
    trace_event_counter_bank #(
      .NUM_EVENTS(NE), .COUNTER_W((g == 0) ? 40 : 8),
      .SATURATE(g == 2), .FREEZE_ON_OVF(g != 2)
    ) dut (.clk(clk), .rst(rst), .bus(bus));
  end

  // Reference model: counts as plain integers reduced modulo 2^width.
  int              cw  [NC] = '{40, 8, 8};
  bit              sat [NC] = '{1'b0, 1'b0, 1'b1};
  bit              frz [NC] = '{1'b1, 1'b1, 1'b0};
  longint unsigned m_cnt [NC][NE];
  longint unsigned m_sh  [NC][NE];
  bit [NE-1:0]     m_ovf [NC];
  bit [NE-1:0]     m_ev  [NC];
  int              m_mode [NC];
  bit              m_rdv [NC];
  bit [31:0]       m_rdd [NC];

  int nassert = 0;
  int nfail   = 0;

  function automatic longint unsigned cmax(int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  task automatic model_step();
    for (int c = 0; c < NC; c++) begin
      longint unsigned mx, v;
      bit hie, anyovf, counting;
      mx = cmax(cw[c]);
      hie = hi && (cw[c] > 32);
      if (rst) begin
        for (int i = 0; i < NE; i++) begin m_cnt[c][i] = 0; m_sh[c][i] = 0; end
        m_ovf[c] = '0; m_ev[c] = '0; m_mode[c] = M_IDLE; m_rdv[c] = 1'b0; m_rdd[c] = 32'd0;
        continue;
      end
      if (rreq) begin
        v = 0;
        if (sel < NE) v = rsh ? m_sh[c][sel] : m_cnt[c][sel];
        m_rdd[c] = hie ? v[63:32] : v[31:0];
      end
      m_rdv[c] = rreq;
      counting = (m_mode[c] == M_RUN);
      anyovf = 1'b0;
      for (int i = 0; i < NE; i++) begin
        if (clr) begin
          m_cnt[c][i] = 0; m_sh[c][i] = 0; m_ovf[c][i] = 1'b0;
        end else begin
          if (snap) m_sh[c][i] = m_cnt[c][i];
          if (wen && sel == i) begin
            if (hie) m_cnt[c][i] = ((m_cnt[c][i] & 64'hFFFF_FFFF) | (longint'(wd) << 32)) & mx;
            else     m_cnt[c][i] = ((m_cnt[c][i] & ~64'hFFFF_FFFF) | longint'(wd)) & mx;
          end else if (counting && m_ev[c][i]) begin
            if (m_cnt[c][i] == mx) begin
              m_ovf[c][i] = 1'b1;
              anyovf = 1'b1;
              m_cnt[c][i] = sat[c] ? mx : 0;
            end else begin
              m_cnt[c][i] = m_cnt[c][i] + 1;
            end
          end
        end
      end
      m_ev[c] = ev;
      if (m_mode[c] == M_IDLE) begin
        if (en) m_mode[c] = M_RUN;
      end else if (m_mode[c] == M_RUN) begin
        if (!en) m_mode[c] = M_IDLE;
        else if (frz[c] && anyovf) m_mode[c] = M_FROZEN;
      end else begin
        if (unf || clr) m_mode[c] = en ? M_RUN : M_IDLE;
      end
    end
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("rd_valid[cfg%0d]", c), 64'(rdv_o[c]), 64'(m_rdv[c]));
      chk($sformatf("rd_data[cfg%0d]", c), 64'(rdd_o[c]), 64'(m_rdd[c]));
      chk($sformatf("ovf_flags[cfg%0d]", c), 64'(ovf_o[c]), 64'(m_ovf[c]));
      chk($sformatf("frozen[cfg%0d]", c), 64'(frz_o[c]), 64'(m_mode[c] == M_FROZEN));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic rd(int s, bit h, bit sh);
    sel = 6'(s); hi = h; rsh = sh; rreq = 1'b1;
    cyc();
    rreq = 1'b0; hi = 1'b0; rsh = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ev = '0; en = 1'b0; unf = 1'b0; snap = 1'b0; clr = 1'b0;
    hi = 1'b0; rsh = 1'b0; rreq = 1'b0; wen = 1'b0; sel = 6'd0; wd = 32'd0;
    cyc(); cyc();
    for (int c = 0; c < NC; c++) begin
      chk("reset_frozen", 64'(frz_o[c]), 64'd0);
      chk("reset_ovf", 64'(ovf_o[c]), 64'd0);
      chk("reset_rd_valid", 64'(rdv_o[c]), 64'd0);
    end
    rst = 1'b0;

    // Five strobes on event 3 are readable two cycles after the last one.
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin ev = '0; ev[3] = 1'b1; cyc(); end
    ev = '0; cyc();
    rd(3, 1'b0, 1'b0);
    for (int c = 0; c < NC; c++) chk("count5", 64'(rdd_o[c]), 64'd5);
    rd(4, 1'b0, 1'b0);
    for (int c = 0; c < NC; c++) chk("other_zero", 64'(rdd_o[c]), 64'd0);

    // Counter 0 starts at FE. The 8-bit wrap build freezes and the saturating build holds at FF.
    wen = 1'b1; sel = 6'd0; wd = 32'h0000_00FE; cyc(); wen = 1'b0;
    ev[0] = 1'b1; cyc(); cyc(); ev = '0; cyc();
    chk("wrap_frozen", 64'(frz_o[1]), 64'd1);
    chk("wrap_ovf0", 64'(ovf_o[1][0]), 64'd1);
    ev[0] = 1'b1; cyc(); ev = '0; cyc();
    rd(0, 1'b0, 1'b0);
    chk("wrap_ignored_frozen", 64'(rdd_o[1]), 64'd0);
    chk("sat_hold", 64'(rdd_o[2]), 64'hFF);
    chk("sat_ovf0", 64'(ovf_o[2][0]), 64'd1);
    chk("sat_not_frozen", 64'(frz_o[2]), 64'd0);
    unf = 1'b1; cyc(); unf = 1'b0;
    chk("unfrozen", 64'(frz_o[1]), 64'd0);
    ev[0] = 1'b1; cyc(); ev = '0; cyc();
    rd(0, 1'b0, 1'b0);
    chk("wrap_after_unfreeze", 64'(rdd_o[1]), 64'd1);
    chk("wide_no_wrap", 64'(rdd_o[0]), 64'h102);

    // A write beats a coincident increment. Clear beats both a write and a snapshot.
    ev[5] = 1'b1; cyc(); ev = '0;
    wen = 1'b1; sel = 6'd5; wd = 32'h55; cyc(); wen = 1'b0; cyc();
    rd(5, 1'b0, 1'b0);
    for (int c = 0; c < NC; c++) chk("write_wins", 64'(rdd_o[c]), 64'h55);
    clr = 1'b1; wen = 1'b1; snap = 1'b1; sel = 6'd5; wd = 32'h77; cyc();
    clr = 1'b0; wen = 1'b0; snap = 1'b0;
    rd(5, 1'b0, 1'b0);
    for (int c = 0; c < NC; c++) chk("clear_live", 64'(rdd_o[c]), 64'd0);
    rd(5, 1'b0, 1'b1);
    for (int c = 0; c < NC; c++) chk("clear_shadow", 64'(rdd_o[c]), 64'd0);
    for (int c = 0; c < NC; c++) chk("clear_flags", 64'(ovf_o[c]), 64'd0);

    // On the 40-bit build, a carry from the low half ripples into the high half.
    wen = 1'b1; sel = 6'd9; hi = 1'b1; wd = 32'hAB; cyc();
    hi = 1'b0; wd = 32'hFFFF_FFFF; cyc(); wen = 1'b0;
    ev[9] = 1'b1; cyc(); ev = '0; cyc();
    rd(9, 1'b1, 1'b0);
    chk("hi_carry", 64'(rdd_o[0]), 64'hAC);
    rd(9, 1'b0, 1'b0);
    chk("lo_wrapped", 64'(rdd_o[0]), 64'd0);
    clr = 1'b1; cyc(); clr = 1'b0;

    // The shadow keeps the value at snapshot time while the live counter keeps moving.
    ev[7] = 1'b1;
    wen = 1'b1; sel = 6'd7; wd = 32'd10; cyc(); wen = 1'b0;
    snap = 1'b1; cyc(); snap = 1'b0; cyc(); cyc(); cyc();
    rd(7, 1'b0, 1'b1);
    for (int c = 0; c < NC; c++) chk("shadow10", 64'(rdd_o[c]), 64'd10);
    rd(7, 1'b0, 1'b0);
    nassert++;
    assert (rdd_o[0] > 32'd10) else begin
      nfail++;
      $error("FAIL live_gt_shadow: observed %0d expected above 10", rdd_o[0]);
    end
    ev = '0;
    rd(NE, 1'b0, 1'b0);
    for (int c = 0; c < NC; c++) begin
      chk("oob_data", 64'(rdd_o[c]), 64'd0);
      chk("oob_valid", 64'(rdv_o[c]), 64'd1);
    end

    // Randomized traffic, checked every cycle against the model.
    for (int k = 0; k < 3000; k++) begin
      ev   = NE'({$urandom(), $urandom()});
      en   = ($urandom_range(0, 15) != 0);
      unf  = ($urandom_range(0, 7) == 0);
      snap = ($urandom_range(0, 7) == 0);
      clr  = ($urandom_range(0, 63) == 0);
      rreq = ($urandom_range(0, 1) == 1);
      sel  = 6'($urandom_range(0, 35));
      hi   = ($urandom_range(0, 1) == 1);
      rsh  = ($urandom_range(0, 1) == 1);
      wen  = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 2))
        0:       wd = 32'hFFFF_FFFF;
        1:       wd = 32'h0000_00FF;
        default: wd = $urandom();
      endcase
      rst  = ($urandom_range(0, 255) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
